adder_amba_pipe: RTL
====================

ADDER_AMBA_PIPE -- requirements
Module: adder_amba_pipe

Interface
REQ-001 SHALL have parameter C_S_AXI_DATA_WIDTH, default 32, register/operand width (multiple of 8, 32 or 64).
REQ-002 SHALL have parameter C_S_AXI_ADDR_WIDTH, default 5, byte address width (>=5).
REQ-003 SHALL have parameter PIPE_STAGES, default 2, compute latency in cycles (1..8).
REQ-004 SHALL have one clock and an asynchronous, active-low reset: S_AXI_ACLK (clock), then S_AXI_ARESETN (reset).
REQ-005 S_AXI_ACLK  in  1  clock, all logic rising-edge.
REQ-006 S_AXI_ARESETN  in  1  async active-low reset.
REQ-007 S_AXI_AWADDR/AWPROT/AWVALID in, AWREADY out  ADDR_WIDTH/3/1/1  AXI4-Lite write address.
REQ-008 S_AXI_WDATA/WSTRB/WVALID in, WREADY out  DATA_WIDTH/DATA_WIDTH/8/1/1  write data.
REQ-009 S_AXI_BRESP/BVALID out, BREADY in  2/1/1  write response.
REQ-010 S_AXI_ARADDR/ARPROT/ARVALID in, ARREADY out  ADDR_WIDTH/3/1/1  read address.
REQ-011 S_AXI_RDATA/RRESP/RVALID out, RREADY in  DATA_WIDTH/2/1/1  read data.
REQ-012 o_leds  out  4  RESULT[3:0].

Function
REQ-013 Register map (word offsets): 0x00 OPA rw, 0x04 OPB rw, 0x08 RESULT ro, 0x0C CTRL rw, 0x10 STATUS ro, 0x14 COUNT ro (completed operations, wraps at 2^DATA_WIDTH).
REQ-014 CTRL: bit0 START (self-clearing, reads 0), bit1 OP (0 add, 1 sub), bit2 ACC (1: RESULT <- RESULT op OPB; 0: RESULT <- OPA op OPB); other bits read 0.
REQ-015 STATUS: bit0 BUSY, bit1 DONE, bit2 CARRY (add carry-out / sub borrow), bit3 OVF (signed overflow), bit4 DROP (start while busy); other bits 0.
REQ-016 AW and W accepted independently in either order: AWREADY=1 while no address latched and BVALID=0; WREADY likewise for data; each ready high one cycle per handshake.
REQ-017 Once both address and data latched: register write (honouring WSTRB per byte) performed that cycle, BVALID=1 next cycle, held until BREADY; no new AW/W accepted while BVALID=1.
REQ-018 Read: ARREADY=1 for one cycle when ARVALID=1 and RVALID=0; RDATA/RVALID registered next cycle; RVALID and RDATA held stable until RREADY.
REQ-019 BRESP/RRESP = 2'b00 for mapped offsets; 2'b10 (SLVERR) for unmapped offsets or writes to RO registers; such writes have no effect, such reads return 0.
REQ-020 Write of CTRL with START=1 and BUSY=0: capture operands, set BUSY, clear DONE/DROP; after exactly PIPE_STAGES cycles update RESULT, CARRY, OVF, increment COUNT, clear BUSY, set DONE, same edge.
REQ-021 Write of CTRL with START=1 and BUSY=1: OP/ACC updated, operation ignored, DROP set sticky until next accepted start.
REQ-022 Arithmetic modulo 2^DATA_WIDTH; OVF from sign bits of operands and result; ACC uses RESULT value at launch.
REQ-023 Simultaneous read and write same register in one cycle: read returns pre-write value; simultaneous completion and STATUS read returns pre-completion value.

Reset
REQ-024 While S_AXI_ARESETN=0: all registers, COUNT, STATUS, pipeline and handshake state clear to 0; all READY/VALID outputs 0; RDATA, BRESP, RRESP 0; o_leds 0.
REQ-025 Reset asserted mid-operation or mid-handshake aborts it; no RESULT update or response after release.
REQ-026 First AW/W/AR handshake possible on the first rising edge after release.

Verification
REQ-027 OPA=0x0000AAAA, OPB=0xBBBB0000, CTRL=0x1 -> after PIPE_STAGES, RESULT=0xBBBBAAAA, DONE=1, CARRY=0, COUNT=1, o_leds=0xA.
REQ-028 OPA=0x7FFFFFFF, OPB=1, CTRL=0x1 -> RESULT=0x80000000, OVF=1, CARRY=0; OPA=0, OPB=1, CTRL=0x3 -> RESULT=0xFFFFFFFF, CARRY=1 (borrow).
REQ-029 RESULT=5, OPB=3, CTRL=0x5 issued three times -> RESULT=14, COUNT incremented by 3.
REQ-030 CTRL=0x1 then CTRL=0x1 again while BUSY=1 -> one RESULT update only, STATUS.DROP=1, COUNT +1.
REQ-031 W before AW, BREADY low 5 cycles, read of 0x1C, write to 0x08 -> BVALID held 5 cycles, OKAY; read RRESP=2'b10 RDATA=0; write BRESP=2'b10, RESULT unchanged.
REQ-032 Reset asserted one cycle after START -> all outputs 0, RESULT=0, COUNT=0, no DONE after release.

Source files
------------

// File: rtl/adder_amba_pipe.sv
// rtl/adder_amba_pipe.sv - AXI4-Lite slave wrapping an add/sub unit with fixed compute latency
module adder_amba_pipe #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 5,
    parameter int PIPE_STAGES        = 2
) (
    input  logic                              S_AXI_ACLK,
    input  logic                              S_AXI_ARESETN,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_AWADDR,
    input  logic [2:0]                        S_AXI_AWPROT,
    input  logic                              S_AXI_AWVALID,
    output logic                              S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   S_AXI_WSTRB,
    input  logic                              S_AXI_WVALID,
    output logic                              S_AXI_WREADY,
    output logic [1:0]                        S_AXI_BRESP,
    output logic                              S_AXI_BVALID,
    input  logic                              S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_ARADDR,
    input  logic [2:0]                        S_AXI_ARPROT,
    input  logic                              S_AXI_ARVALID,
    output logic                              S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_RDATA,
    output logic [1:0]                        S_AXI_RRESP,
    output logic                              S_AXI_RVALID,
    input  logic                              S_AXI_RREADY,
    output logic [3:0]                        o_leds
);
    localparam int DW = C_S_AXI_DATA_WIDTH;
    localparam int NB = DW / 8;
    localparam int IW = C_S_AXI_ADDR_WIDTH - 2;

    localparam logic [IW-1:0] IDX_OPA    = IW'(0);
    localparam logic [IW-1:0] IDX_OPB    = IW'(1);
    localparam logic [IW-1:0] IDX_RESULT = IW'(2);
    localparam logic [IW-1:0] IDX_CTRL   = IW'(3);
    localparam logic [IW-1:0] IDX_STATUS = IW'(4);
    localparam logic [IW-1:0] IDX_COUNT  = IW'(5);

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    logic          aw_full, w_full;
    logic [IW-1:0] widx;
    logic [DW-1:0] wdata_q;
    logic [NB-1:0] wstrb_q;
    logic          bvalid, rvalid;
    logic [1:0]    bresp, rresp;
    logic [DW-1:0] rdata;

    logic [DW-1:0] opa, opb, result, count;
    logic          ctrl_op, ctrl_acc;
    logic          busy, done, carry, ovf, drop;
    logic [3:0]    cnt;
    logic [DW-1:0] a_q, b_q;
    logic          op_q;

    logic          wr_fire, wr_ok, ctrl_hit, start_req;
    logic [IW-1:0] rd_idx;
    logic [DW-1:0] rd_val;
    logic          rd_ok;
    logic [DW:0]   sum_ext;
    logic          ovf_c;
    logic          unused_ok;

    assign S_AXI_AWREADY = S_AXI_ARESETN & ~aw_full & ~bvalid;
    assign S_AXI_WREADY  = S_AXI_ARESETN & ~w_full & ~bvalid;
    assign S_AXI_ARREADY = S_AXI_ARESETN & S_AXI_ARVALID & ~rvalid;
    assign S_AXI_BVALID  = bvalid;
    assign S_AXI_BRESP   = bresp;
    assign S_AXI_RVALID  = rvalid;
    assign S_AXI_RDATA   = rdata;
    assign S_AXI_RRESP   = rresp;
    assign o_leds        = result[3:0];

    assign unused_ok = &{1'b0, S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

    function automatic logic [DW-1:0] merge_bytes(input logic [DW-1:0] old_v,
                                                  input logic [DW-1:0] new_v,
                                                  input logic [NB-1:0] strb);
        logic [DW-1:0] r;
        r = old_v;
        for (int i = 0; i < NB; i++) begin
            if (strb[i]) r[8*i +: 8] = new_v[8*i +: 8];
        end
        return r;
    endfunction

    assign wr_fire   = aw_full & w_full;
    assign ctrl_hit  = wr_fire && (widx == IDX_CTRL) && wstrb_q[0];
    assign start_req = ctrl_hit && wdata_q[0];
    assign rd_idx    = S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:2];

    always_comb begin
        wr_ok = 1'b0;
        case (widx)
            IDX_OPA, IDX_OPB, IDX_CTRL: wr_ok = 1'b1;
            default:                    wr_ok = 1'b0;
        endcase
    end

    always_comb begin
        rd_val = '0;
        rd_ok  = 1'b1;
        case (rd_idx)
            IDX_OPA:    rd_val = opa;
            IDX_OPB:    rd_val = opb;
            IDX_RESULT: rd_val = result;
            IDX_CTRL:   rd_val = {{(DW-3){1'b0}}, ctrl_acc, ctrl_op, 1'b0};
            IDX_STATUS: rd_val = {{(DW-5){1'b0}}, drop, ovf, carry, done, busy};
            IDX_COUNT:  rd_val = count;
            default:    rd_ok  = 1'b0;
        endcase
    end

    // Borrow on subtract shows up as the extension bit of the wide difference.
    always_comb begin
        sum_ext = '0;
        ovf_c   = 1'b0;
        if (op_q) begin
            sum_ext = {1'b0, a_q} - {1'b0, b_q};
            ovf_c   = (a_q[DW-1] != b_q[DW-1]) && (sum_ext[DW-1] != a_q[DW-1]);
        end else begin
            sum_ext = {1'b0, a_q} + {1'b0, b_q};
            ovf_c   = (a_q[DW-1] == b_q[DW-1]) && (sum_ext[DW-1] != a_q[DW-1]);
        end
    end

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            aw_full <= 1'b0;
            w_full  <= 1'b0;
            widx    <= '0;
            wdata_q <= '0;
            wstrb_q <= '0;
            bvalid  <= 1'b0;
            bresp   <= RESP_OKAY;
            rvalid  <= 1'b0;
            rdata   <= '0;
            rresp   <= RESP_OKAY;
        end else begin
            if (S_AXI_AWVALID && S_AXI_AWREADY) begin
                aw_full <= 1'b1;
                widx    <= S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:2];
            end
            if (S_AXI_WVALID && S_AXI_WREADY) begin
                w_full  <= 1'b1;
                wdata_q <= S_AXI_WDATA;
                wstrb_q <= S_AXI_WSTRB;
            end
            if (wr_fire) begin
                aw_full <= 1'b0;
                w_full  <= 1'b0;
                bvalid  <= 1'b1;
                bresp   <= wr_ok ? RESP_OKAY : RESP_SLVERR;
            end else if (bvalid && S_AXI_BREADY) begin
                bvalid <= 1'b0;
            end
            if (S_AXI_ARVALID && S_AXI_ARREADY) begin
                rvalid <= 1'b1;
                rdata  <= rd_ok ? rd_val : '0;
                rresp  <= rd_ok ? RESP_OKAY : RESP_SLVERR;
            end else if (rvalid && S_AXI_RREADY) begin
                rvalid <= 1'b0;
            end
        end
    end

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            opa      <= '0;
            opb      <= '0;
            result   <= '0;
            count    <= '0;
            ctrl_op  <= 1'b0;
            ctrl_acc <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            carry    <= 1'b0;
            ovf      <= 1'b0;
            drop     <= 1'b0;
            cnt      <= '0;
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= 1'b0;
        end else begin
            if (busy) begin
                if (cnt == 4'd1) begin
                    result <= sum_ext[DW-1:0];
                    carry  <= sum_ext[DW];
                    ovf    <= ovf_c;
                    count  <= count + DW'(1);
                    busy   <= 1'b0;
                    done   <= 1'b1;
                end else begin
                    cnt <= cnt - 4'd1;
                end
            end

            if (wr_fire && widx == IDX_OPA) opa <= merge_bytes(opa, wdata_q, wstrb_q);
            if (wr_fire && widx == IDX_OPB) opb <= merge_bytes(opb, wdata_q, wstrb_q);
            if (ctrl_hit) begin
                ctrl_op  <= wdata_q[1];
                ctrl_acc <= wdata_q[2];
            end

            // Launch samples RESULT as it stands now, so accumulate chains correctly.
            if (start_req) begin
                if (busy) begin
                    drop <= 1'b1;
                end else begin
                    busy <= 1'b1;
                    done <= 1'b0;
                    drop <= 1'b0;
                    cnt  <= 4'(PIPE_STAGES);
                    a_q  <= wdata_q[2] ? result : opa;
                    b_q  <= opb;
                    op_q <= wdata_q[1];
                end
            end
        end
    end
endmodule
